qaddsub_pipe: RTL and testbench
===============================

Name: qaddsub_pipe

Overview:
- Parametrised, pipelined sign-magnitude Q-format adder/subtractor with an internal accumulator.
- Supports saturating or wrapping overflow, an overflow flag and a saturating overflow counter.
- Uses valid/ready handshakes on both sides.
- Next-generation arithmetic primitive for the error-estimate datapath. Replaces single-cycle start/valid adders where back-to-back accumulation and downstream backpressure are needed.

Parameters:
- Q, 23, number of fractional bits. Informational only: it does not change the arithmetic, since sign-magnitude add is format-agnostic.
- N, 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
- SAT, 1, 1 = saturate on magnitude overflow, 0 = wrap modulo 2^(N-1).
- CW, 16, width of the overflow event counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  input operation valid.
- in_rdy  out  1  block can accept an operation this cycle.
- op  in  2  00 = a+b, 01 = a-b, 10 = acc+a (b ignored), 11 = load acc with a (b ignored).
- a  in  N  operand A, sign-magnitude.
- b  in  N  operand B, sign-magnitude.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts the result.
- res  out  N  result, sign-magnitude.
- res_ovf  out  1  overflow occurred for this result; qualified by out_vld.
- acc_val  out  N  current accumulator contents.
- ovf_cnt  out  CW  number of overflowed results produced; saturates at all ones.

Behaviour:
- Reset: out_vld=0, res=0, res_ovf=0, acc_val=0, ovf_cnt=0, stage-1 valid=0. A reset mid-operation discards all in-flight operations with no output. in_rdy=1 in the cycle after reset.
- Pipeline has two registers: S1 (operands + op) and OUT (result).
- Transfer into S1 happens when in_vld && in_rdy.
- Arithmetic is performed on the S1->OUT transfer. Latency is exactly 2 cycles from acceptance to out_vld when out_rdy=1.
- Handshake: out_adv = !out_vld || out_rdy. S1 moves to OUT when S1 valid && out_adv. in_rdy = !s1_vld || out_adv (combinational from out_rdy).
- OUT holds res and res_ovf stable while out_vld && !out_rdy.
- Full throughput: 1 op per cycle while out_rdy=1.
- Sign handling in S1:
  - op=01: invert b's sign.
  - op=10: the second operand is acc_val, sampled at the S1->OUT transfer, not at input acceptance.
  - An input negative zero (sign 1, magnitude 0) is treated as +0.
- Same signs: magnitude = |x|+|y| computed N bits wide; sign = common sign.
  - If the sum is >= 2^(N-1), overflow=1.
  - SAT=1: magnitude forced to all ones, sign kept.
  - SAT=0: magnitude = low N-1 bits of the sum.
- Different signs: magnitude = larger - smaller; sign = sign of the larger magnitude; equal magnitudes give exactly +0. Overflow is impossible.
- Zero result rule: any zero magnitude, including a wrapped one, outputs sign 0.
- Accumulator:
  - op=11: acc <= a (with negative zero normalised to +0); res = that value; ovf=0.
  - op=10: acc <= result, updated on the same edge OUT is loaded.
  - Back-to-back op=10 therefore chains with no bubbles and no hazard.
  - op=00 and op=01 leave acc unchanged.
- ovf_cnt increments on the edge OUT is loaded with an overflowed result and holds at 2^CW-1.
- Simultaneous drain of OUT and load from S1 in the same cycle is legal: no lost or duplicated result.

Test Plan:
- N=32, op=00, a=0x00C00000 (1.5), b=0x80400000 (-0.5), out_rdy=1 -> 2 cycles later out_vld=1, res=0x00800000, res_ovf=0.
- op=01, a=b=0x00400000, then op=00 with a=0x80000000, b=0x00000000 -> res=0x00000000 both times (sign 0).
- op=00, a=0x7FFFFFFF, b=0x00000001: SAT=1 -> res=0x7FFFFFFF, ovf=1, ovf_cnt=1. SAT=0 -> res=0x00000000, ovf=1.
- op=11 a=0x00400000, then three back-to-back op=10 a=0x00400000 -> res sequence 0x00400000, 0x00800000, 0x00C00000, 0x01000000; final acc_val=0x01000000; no stall cycles.
- out_rdy=0 for 4 cycles while in_vld=1 with a distinct sequence -> exactly 2 ops accepted and in_rdy=0 afterwards. res stays stable. On out_rdy=1 all results arrive in order with none dropped or duplicated.
- rst asserted for 1 cycle with S1 and OUT both valid and acc nonzero -> next cycle out_vld=0, acc_val=0, ovf_cnt=0, in_rdy=1, and no stale result ever appears.

Source files
------------

// File: rtl/qaddsub_pipe.sv
// qaddsub_pipe: two-stage sign-magnitude Q-format add/sub with accumulator and overflow counting
module qaddsub_pipe #(
    parameter int Q   = 23,
    parameter int N   = 32,
    parameter bit SAT = 1,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [1:0]    op,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [N-1:0]  res,
    output logic          res_ovf,
    output logic [N-1:0]  acc_val,
    output logic [CW-1:0] ovf_cnt
);
    if (Q < 0 || Q > N - 1) begin : g_q_check
        $error("qaddsub_pipe: Q must lie within the magnitude field");
    end
    logic          s1_vld_q, s1_vld_d;
    logic [1:0]    s1_op_q, s1_op_d;
    logic [N-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic          out_vld_q, out_vld_d;
    logic [N-1:0]  res_q, res_d;
    logic          res_ovf_q, res_ovf_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] ovf_cnt_q, ovf_cnt_d;
    logic          out_adv, s1_mv, in_fire;
    logic          xs, ys, rs, r_ovf;
    logic [N-2:0]  xm, ym, rm;
    logic [N-1:0]  sum, r;
    // Arithmetic on the S1 operands; the accumulator is read here so chained acc ops see the latest value
    always_comb begin
        xm    = s1_a_q[N-2:0];
        xs    = s1_a_q[N-1] & |xm;
        ym    = s1_op_q[1] ? acc_q[N-2:0] : s1_b_q[N-2:0];
        ys    = (s1_op_q == 2'b10 ? acc_q[N-1] : s1_b_q[N-1] ^ (s1_op_q == 2'b01)) & |ym;
        sum   = {1'b0, xm} + {1'b0, ym};
        r_ovf = (xs == ys) && sum[N-1] && (s1_op_q != 2'b11);
        rm    = s1_op_q == 2'b11 ? xm :
                xs == ys ? ((r_ovf && SAT) ? '1 : sum[N-2:0]) :
                (xm >= ym ? xm - ym : ym - xm);
        rs    = s1_op_q == 2'b11 ? xs : (xs == ys || xm >= ym) ? xs : ys;
        r     = {rs & |rm, rm};
    end
    // Handshake and next-state for both pipeline registers, accumulator and counter
    always_comb begin
        out_adv   = !out_vld_q || out_rdy;
        in_rdy    = !s1_vld_q || out_adv;
        in_fire   = in_vld && in_rdy;
        s1_mv     = s1_vld_q && out_adv;
        s1_vld_d  = in_fire ? 1'b1 : (s1_mv ? 1'b0 : s1_vld_q);
        s1_op_d   = in_fire ? op : s1_op_q;
        s1_a_d    = in_fire ? a : s1_a_q;
        s1_b_d    = in_fire ? b : s1_b_q;
        out_vld_d = s1_mv ? 1'b1 : (out_rdy ? 1'b0 : out_vld_q);
        res_d     = s1_mv ? r : res_q;
        res_ovf_d = s1_mv ? r_ovf : res_ovf_q;
        acc_d     = (s1_mv && s1_op_q[1]) ? r : acc_q;
        ovf_cnt_d = (s1_mv && r_ovf && !(&ovf_cnt_q)) ? ovf_cnt_q + CW'(1) : ovf_cnt_q;
    end
    // State registers with synchronous reset discarding anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_op_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            out_vld_q <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            acc_q     <= '0;
            ovf_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_op_q   <= s1_op_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            out_vld_q <= out_vld_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            acc_q     <= acc_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
    assign out_vld = out_vld_q;
    assign res     = res_q;
    assign res_ovf = res_ovf_q;
    assign acc_val = acc_q;
    assign ovf_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_qaddsub_pipe.sv
// tb_qaddsub_pipe: directed vectors with a queue scoreboard and a decoupled output monitor
module tb_qaddsub_pipe;
    localparam int N   = 32;
    localparam int CW  = 16;
    localparam bit SAT = 1;
    logic          clk = 1'b0;
    logic          rst, in_vld, out_rdy;
    logic [1:0]    op;
    logic [N-1:0]  a, b;
    logic          in_rdy, out_vld, res_ovf;
    logic [N-1:0]  res, acc_val;
    logic [CW-1:0] ovf_cnt;
    typedef struct packed {
        logic [N-1:0] r;
        logic         o;
    } exp_t;
    exp_t         q[$];
    int           checks = 0, errors = 0, pops = 0, stalls = 0;
    logic [N-1:0] prev_res;
    logic         prev_ovf;
    logic         prev_stall = 1'b0;
    qaddsub_pipe #(.Q(23), .N(N), .SAT(SAT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .op(op), .a(a), .b(b),
        .out_vld(out_vld), .out_rdy(out_rdy), .res(res), .res_ovf(res_ovf),
        .acc_val(acc_val), .ovf_cnt(ovf_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] er, input logic eo);
        bit ok;
        int n;
        n = 0;
        in_vld = 1'b1; op = o; a = x; b = y;
        do begin
            @(negedge clk);
            ok = in_rdy;
            @(posedge clk);
            #1;
            n++;
            if (!ok) stalls++;
        end while (!ok && n < 20);
        if (ok) q.push_back(exp_t'{er, eo});
        else chk("issue_timeout", 64'd0, 64'd1);
        in_vld = 1'b0;
    endtask
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int s0, p0, k;
        exp_t e;
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_vld && !out_rdy && prev_stall)
                    chk("hold_res", {31'd0, res, res_ovf}, {31'd0, prev_res, prev_ovf});
                prev_stall = !rst && out_vld && !out_rdy;
                prev_res   = res;
                prev_ovf   = res_ovf;
                if (!rst && out_vld && out_rdy) begin
                    if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                    else begin
                        e = q.pop_front();
                        pops++;
                        chk("res", 64'(res), 64'(e.r));
                        chk("res_ovf", 64'(res_ovf), 64'(e.o));
                    end
                end
            end
        join_none
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_acc", 64'(acc_val), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        // 1.5 + (-0.5) = 1.0, with the two-cycle latency
        issue(2'b00, 32'h00C00000, 32'h80400000, 32'h00800000, 1'b0);
        @(posedge clk);
        #1;
        chk("latency", 64'(out_vld), 64'd1);
        drain();
        // equal subtraction and negative zero both give +0
        issue(2'b01, 32'h00400000, 32'h00400000, 32'h00000000, 1'b0);
        issue(2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
        drain();
        // positive overflow
        issue(2'b00, 32'h7FFFFFFF, 32'h00000001, SAT ? 32'h7FFFFFFF : 32'h00000000, 1'b1);
        drain();
        chk("ovf_cnt_1", 64'(ovf_cnt), 64'd1);
        // negative result, negative overflow (wrap would hit zero), normalised load of -0
        issue(2'b01, 32'h00400000, 32'h00C00000, 32'h80800000, 1'b0);
        issue(2'b00, 32'hFFFFFFFF, 32'h80000001, SAT ? 32'hFFFFFFFF : 32'h00000000, 1'b1);
        issue(2'b11, 32'h80000000, 32'h12345678, 32'h00000000, 1'b0);
        drain();
        chk("ovf_cnt_2", 64'(ovf_cnt), 64'd2);
        chk("acc_neg_zero", 64'(acc_val), 64'd0);
        // back-to-back accumulation chain
        s0 = stalls;
        issue(2'b11, 32'h00400000, 32'hDEADBEEF, 32'h00400000, 1'b0);
        issue(2'b10, 32'h00400000, 32'hFFFFFFFF, 32'h00800000, 1'b0);
        issue(2'b10, 32'h00400000, 32'h00000000, 32'h00C00000, 1'b0);
        issue(2'b10, 32'h00400000, 32'h80000000, 32'h01000000, 1'b0);
        chk("chain_stalls", 64'(stalls - s0), 64'd0);
        drain();
        chk("acc_chain", 64'(acc_val), 64'h01000000);
        issue(2'b10, 32'h81800000, 32'h00000000, 32'h80800000, 1'b0);
        drain();
        chk("acc_neg", 64'(acc_val), 64'h80800000);
        // downstream backpressure for four cycles
        p0 = pops;
        k = 0;
        out_rdy = 1'b0;
        in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 2'b00; a = 32'h1 + 32'(k); b = 32'h10;
            @(negedge clk);
            if (in_rdy) begin
                q.push_back(exp_t'{32'h11 + 32'(k), 1'b0});
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        chk("stall_accepted", 64'(k), 64'd2);
        chk("stall_in_rdy", 64'(in_rdy), 64'd0);
        out_rdy = 1'b1;
        drain();
        chk("stall_pops", 64'(pops - p0), 64'd2);
        // reset with S1 and OUT both full and accumulator nonzero
        out_rdy = 1'b0;
        in_vld = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("pre_rst_out_vld", 64'(out_vld), 64'd1);
        chk("pre_rst_in_rdy", 64'(in_rdy), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_acc", 64'(acc_val), 64'd0);
        chk("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        out_rdy = 1'b1;
        p0 = pops;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_out", 64'(pops - p0), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
